nts_engine_ctrl: RTL and testbench
==================================

// Module: nts_engine_ctrl
// PURPOSE
//  Parametrised packet-lifecycle controller for one NTS engine.
//  Tracks each packet through copy from the dispatcher FIFO, parse, optional transmit and release.
//  Releasing a packet means pulsing the dispatcher discard.
//  Adds per-stage timeouts, overflow/error drop paths and saturating statistics counters.
//  Sits between the dispatcher, rx buffer, parser ctrl and tx stage inside the engine.
// PARAMETERS
//  TIMEOUT_WIDTH   16    width of stage timeout counter
//  TIMEOUT_CYCLES  1000  max cycles in COPY/PARSE/TX; must be >=2 and < 2**TIMEOUT_WIDTH
//  CNT_WIDTH       32    width of each statistics counter
//  TX_ENABLE       1     1: parse success -> TX stage; 0: parse success -> release directly
// PORTS
//  i_clk                          in   1          clock
//  i_areset                       in   1          reset, asynchronous, active-high
//  o_busy                         out  1          packet in flight
//  i_dispatch_packet_available    in   1          dispatcher holds a packet
//  i_dispatch_fifo_empty          in   1          dispatcher FIFO empty
//  o_dispatch_packet_read_discard out  1          1-cycle release pulse to dispatcher
//  o_clear                        out  1          clear to rx buffer/parser; =(state==RESET)
//  i_copy_overflow                in   1          rx buffer overflow during copy
//  o_parse_start                  out  1          1-cycle parser start pulse
//  i_parse_done                   in   1          parser finished
//  i_parse_error                  in   1          parser rejected packet (valid with done or alone)
//  o_tx_start                     out  1          1-cycle tx start pulse
//  i_tx_done                      in   1          tx finished
//  o_cnt_processed                out  CNT_WIDTH  packets completed OK
//  o_cnt_dropped                  out  CNT_WIDTH  packets dropped (overflow/error/timeout)
//  o_cnt_timeout                  out  CNT_WIDTH  stage timeouts
//  o_state                        out  4          current state, for debug
// BEHAVIOUR
//  Reset values: state=RESET, o_state=0, o_clear=1, all other outputs 0.
//  Reset values (cont.): timeout counter 0, all statistics counters 0.
//  All outputs are registered except o_clear, which decodes state_reg.
//  States: RESET=0, EMPTY=1, COPY=2, PARSE=3, TX=4, DISCARD=5. Codes 6..15 -> RESET next cycle.
//  RESET: o_busy<=0; -> EMPTY unconditionally after 1 cycle.
//  EMPTY: if available && !fifo_empty -> COPY, o_busy<=1.
//  COPY: overflow -> DISCARD, dropped++. Overflow beats fifo_empty in the same cycle.
//   COPY (cont.): fifo_empty -> PARSE; o_parse_start high for exactly the first PARSE cycle.
//  PARSE: error (with or without done) -> DISCARD, dropped++.
//   PARSE (cont.): done && !error -> TX if TX_ENABLE, with o_tx_start high for the first TX cycle.
//   PARSE (cont.): done && !error -> DISCARD with processed++ if TX_ENABLE=0.
//  TX: tx_done -> DISCARD, processed++.
//  DISCARD: o_dispatch_packet_read_discard=1 for this single cycle; o_busy stays 1; -> RESET.
//  Timeout: counter <=0 on entry to COPY/PARSE/TX, then increments each cycle in those states.
//   If count==TIMEOUT_CYCLES-1 and no exit event that cycle -> DISCARD, timeout++, dropped++.
//   Result: a stalled stage lasts exactly TIMEOUT_CYCLES cycles.
//   Exit events beat timeout in the same cycle.
//  Inputs not belonging to the current state are ignored, e.g. tx_done in PARSE.
//  Statistics counters saturate at all-ones and never wrap. Several may increment in one cycle.
//  Latency: EMPTY->COPY 1 cycle after condition. Terminal event -> discard pulse next cycle.
//   Latency (cont.): discard -> EMPTY 2 cycles later.
//  i_areset mid-packet: immediate return to reset values; no discard pulse is issued.
// TESTING
//  1 Nominal: avail=1, fifo_empty low 4 cyc, parse_done +10, tx_done +5 -> one parse_start, one tx_start, one discard pulse; processed=1; busy 0 in RESET.
//  2 Overflow pulse in COPY (concurrent fifo_empty) -> DISCARD next cyc, dropped=1, no parse_start.
//  3 TIMEOUT_CYCLES=8, parse_done never -> discard exactly 8 cyc after PARSE entry; timeout=1, dropped=1.
//  4 parse_done+parse_error same cycle -> dropped=1, no tx_start.
//  5 tx_done on the timeout cycle -> processed=1, timeout=0.
//  6 TX_ENABLE=0: parse_done -> discard, no tx_start, processed=1.
//  7 CNT_WIDTH=2, 5 error drops -> dropped=3.
//  8 i_areset mid-PARSE -> state 0, counters 0, no discard pulse.

Source files
------------

// File: rtl/nts_engine_ctrl.sv
// Packet-lifecycle controller for one NTS engine: copy, parse, optional tx, release.
// Adds per-stage timeouts, drop paths and saturating statistics counters.
module nts_engine_ctrl #(
    parameter int unsigned TIMEOUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter bit          TX_ENABLE      = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_areset,
    output logic                 o_busy,
    input  logic                 i_dispatch_packet_available,
    input  logic                 i_dispatch_fifo_empty,
    output logic                 o_dispatch_packet_read_discard,
    output logic                 o_clear,
    input  logic                 i_copy_overflow,
    output logic                 o_parse_start,
    input  logic                 i_parse_done,
    input  logic                 i_parse_error,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic [CNT_WIDTH-1:0] o_cnt_processed,
    output logic [CNT_WIDTH-1:0] o_cnt_dropped,
    output logic [CNT_WIDTH-1:0] o_cnt_timeout,
    output logic [3:0]           o_state
);

    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StEmpty   = 4'd1,
        StCopy    = 4'd2,
        StParse   = 4'd3,
        StTx      = 4'd4,
        StDiscard = 4'd5
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_reg;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic                     timeout_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign o_clear     = (state_reg == StReset);
    assign o_state     = state_reg;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_reg                      <= StReset;
            timeout_cnt                    <= '0;
            o_busy                         <= 1'b0;
            o_dispatch_packet_read_discard <= 1'b0;
            o_parse_start                  <= 1'b0;
            o_tx_start                     <= 1'b0;
            o_cnt_processed                <= '0;
            o_cnt_dropped                  <= '0;
            o_cnt_timeout                  <= '0;
        end else begin
            o_dispatch_packet_read_discard <= 1'b0;
            o_parse_start                  <= 1'b0;
            o_tx_start                     <= 1'b0;
            timeout_cnt                    <= timeout_cnt + TIMEOUT_WIDTH'(1);
            unique case (state_reg)
                StReset: begin
                    o_busy    <= 1'b0;
                    state_reg <= StEmpty;
                end
                StEmpty: begin
                    if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                        o_busy      <= 1'b1;
                        timeout_cnt <= '0;
                        state_reg   <= StCopy;
                    end
                end
                StCopy: begin
                    // Overflow wins over copy completion in the same cycle
                    if (i_copy_overflow) begin
                        o_cnt_dropped                  <= sat_inc(o_cnt_dropped);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end else if (i_dispatch_fifo_empty) begin
                        o_parse_start <= 1'b1;
                        timeout_cnt   <= '0;
                        state_reg     <= StParse;
                    end else if (timeout_hit) begin
                        o_cnt_timeout                  <= sat_inc(o_cnt_timeout);
                        o_cnt_dropped                  <= sat_inc(o_cnt_dropped);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end
                end
                StParse: begin
                    if (i_parse_error) begin
                        o_cnt_dropped                  <= sat_inc(o_cnt_dropped);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end else if (i_parse_done) begin
                        if (TX_ENABLE) begin
                            o_tx_start  <= 1'b1;
                            timeout_cnt <= '0;
                            state_reg   <= StTx;
                        end else begin
                            o_cnt_processed                <= sat_inc(o_cnt_processed);
                            o_dispatch_packet_read_discard <= 1'b1;
                            state_reg                      <= StDiscard;
                        end
                    end else if (timeout_hit) begin
                        o_cnt_timeout                  <= sat_inc(o_cnt_timeout);
                        o_cnt_dropped                  <= sat_inc(o_cnt_dropped);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end
                end
                StTx: begin
                    if (i_tx_done) begin
                        o_cnt_processed                <= sat_inc(o_cnt_processed);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end else if (timeout_hit) begin
                        o_cnt_timeout                  <= sat_inc(o_cnt_timeout);
                        o_cnt_dropped                  <= sat_inc(o_cnt_dropped);
                        o_dispatch_packet_read_discard <= 1'b1;
                        state_reg                      <= StDiscard;
                    end
                end
                StDiscard: begin
                    o_busy    <= 1'b0;
                    state_reg <= StReset;
                end
                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= StReset;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Directed bench for nts_engine_ctrl: nominal table plus drop, timeout, saturation
// and async-reset sequences across three parameterisations.
module tb_nts_engine_ctrl;

    logic i_clk = 1'b0;
    logic i_areset = 1'b1;
    always #5 i_clk = ~i_clk;

    // dut_a: TX enabled, timeout 8
    logic a_avail = 0, a_fe = 1, a_ovf = 0, a_pdone = 0, a_perr = 0, a_txd = 0;
    logic a_busy, a_disc, a_clear, a_ps, a_ts;
    logic [31:0] a_proc, a_drop, a_tmo;
    logic [3:0] a_state;
    // dut_b: TX disabled
    logic b_avail = 0, b_fe = 1, b_ovf = 0, b_pdone = 0, b_perr = 0, b_txd = 0;
    logic b_busy, b_disc, b_clear, b_ps, b_ts;
    logic [31:0] b_proc, b_drop, b_tmo;
    logic [3:0] b_state;
    // dut_c: 2-bit counters
    logic c_avail = 0, c_fe = 1, c_ovf = 0, c_pdone = 0, c_perr = 0, c_txd = 0;
    logic c_busy, c_disc, c_clear, c_ps, c_ts;
    logic [1:0] c_proc, c_drop, c_tmo;
    logic [3:0] c_state;

    nts_engine_ctrl #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32), .TX_ENABLE(1'b1))
    dut_a (
        .i_clk(i_clk), .i_areset(i_areset), .o_busy(a_busy),
        .i_dispatch_packet_available(a_avail), .i_dispatch_fifo_empty(a_fe),
        .o_dispatch_packet_read_discard(a_disc), .o_clear(a_clear),
        .i_copy_overflow(a_ovf), .o_parse_start(a_ps), .i_parse_done(a_pdone),
        .i_parse_error(a_perr), .o_tx_start(a_ts), .i_tx_done(a_txd),
        .o_cnt_processed(a_proc), .o_cnt_dropped(a_drop), .o_cnt_timeout(a_tmo),
        .o_state(a_state)
    );

    nts_engine_ctrl #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32), .TX_ENABLE(1'b0))
    dut_b (
        .i_clk(i_clk), .i_areset(i_areset), .o_busy(b_busy),
        .i_dispatch_packet_available(b_avail), .i_dispatch_fifo_empty(b_fe),
        .o_dispatch_packet_read_discard(b_disc), .o_clear(b_clear),
        .i_copy_overflow(b_ovf), .o_parse_start(b_ps), .i_parse_done(b_pdone),
        .i_parse_error(b_perr), .o_tx_start(b_ts), .i_tx_done(b_txd),
        .o_cnt_processed(b_proc), .o_cnt_dropped(b_drop), .o_cnt_timeout(b_tmo),
        .o_state(b_state)
    );

    nts_engine_ctrl #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8), .CNT_WIDTH(2), .TX_ENABLE(1'b1))
    dut_c (
        .i_clk(i_clk), .i_areset(i_areset), .o_busy(c_busy),
        .i_dispatch_packet_available(c_avail), .i_dispatch_fifo_empty(c_fe),
        .o_dispatch_packet_read_discard(c_disc), .o_clear(c_clear),
        .i_copy_overflow(c_ovf), .o_parse_start(c_ps), .i_parse_done(c_pdone),
        .i_parse_error(c_perr), .o_tx_start(c_ts), .i_tx_done(c_txd),
        .o_cnt_processed(c_proc), .o_cnt_dropped(c_drop), .o_cnt_timeout(c_tmo),
        .o_state(c_state)
    );

    typedef struct {
        logic        avail, fe, ovf, pdone, perr, txd;
        logic [3:0]  st;
        logic        busy, clr, disc, ps, ts;
        logic [31:0] proc;
    } vec_t;

    vec_t tbl [17];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic a_to_parse();
        a_avail = 1; a_fe = 0; tick();
        a_avail = 0; a_fe = 1; tick();
    endtask

    task automatic a_back_to_empty();
        a_pdone = 0; a_perr = 0; a_txd = 0; a_ovf = 0;
        tick(); tick();
    endtask

    initial begin
        // avail fe ovf pdone perr txd | state busy clr disc ps ts | processed
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 1, 4'd3, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 1, 0, 0, 4'd4, 1, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 4'd4, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 4'd4, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 4'd5, 1, 0, 1, 0, 0, 1};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 0, 1};
        tbl[16] = '{0, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 0, 1};

        // Reset values
        #12;
        chk("rst_state", 32'(a_state), 0);
        chk("rst_clear", 32'(a_clear), 1);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_disc", 32'(a_disc), 0);
        chk("rst_proc", a_proc, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_tmo", a_tmo, 0);
        @(negedge i_clk);
        i_areset = 0;

        // 1: nominal lifecycle
        for (int i = 0; i < 17; i++) begin
            a_avail = tbl[i].avail; a_fe = tbl[i].fe; a_ovf = tbl[i].ovf;
            a_pdone = tbl[i].pdone; a_perr = tbl[i].perr; a_txd = tbl[i].txd;
            tick();
            chk($sformatf("row%0d_state", i), 32'(a_state), 32'(tbl[i].st));
            chk($sformatf("row%0d_busy", i), 32'(a_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_clear", i), 32'(a_clear), 32'(tbl[i].clr));
            chk($sformatf("row%0d_disc", i), 32'(a_disc), 32'(tbl[i].disc));
            chk($sformatf("row%0d_pstart", i), 32'(a_ps), 32'(tbl[i].ps));
            chk($sformatf("row%0d_tstart", i), 32'(a_ts), 32'(tbl[i].ts));
            chk($sformatf("row%0d_proc", i), a_proc, tbl[i].proc);
        end

        // 2: overflow together with fifo_empty in COPY
        a_avail = 1; a_fe = 0; tick();
        chk("ovf_copy", 32'(a_state), 2);
        a_avail = 0; a_ovf = 1; a_fe = 1; tick();
        chk("ovf_state", 32'(a_state), 5);
        chk("ovf_disc", 32'(a_disc), 1);
        chk("ovf_pstart", 32'(a_ps), 0);
        chk("ovf_drop", a_drop, 1);
        a_ovf = 0; tick();
        chk("ovf_pstart2", 32'(a_ps), 0);
        chk("ovf_reset", 32'(a_state), 0);
        tick();

        // 3: parse stall -> discard exactly 8 cycles after PARSE entry
        a_to_parse();
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("tmo_hold%0d", k), 32'(a_state), 3);
        end
        tick();
        chk("tmo_state", 32'(a_state), 5);
        chk("tmo_disc", 32'(a_disc), 1);
        chk("tmo_tmo", a_tmo, 1);
        chk("tmo_drop", a_drop, 2);
        a_back_to_empty();

        // 4: done and error in the same cycle
        a_to_parse();
        tick();
        a_pdone = 1; a_perr = 1; tick();
        chk("err_state", 32'(a_state), 5);
        chk("err_tstart", 32'(a_ts), 0);
        chk("err_drop", a_drop, 3);
        chk("err_proc", a_proc, 1);
        a_back_to_empty();

        // 5: tx_done lands on the timeout cycle
        a_to_parse();
        a_pdone = 1; tick();
        a_pdone = 0;
        chk("txt_enter", 32'(a_ts), 1);
        for (int k = 0; k < 7; k++) tick();
        chk("txt_hold", 32'(a_state), 4);
        a_txd = 1; tick();
        chk("txt_state", 32'(a_state), 5);
        chk("txt_proc", a_proc, 2);
        chk("txt_tmo", a_tmo, 1);
        chk("txt_drop", a_drop, 3);
        a_back_to_empty();

        // 6: TX disabled -> release straight after parse
        b_avail = 1; b_fe = 0; tick();
        b_avail = 0; b_fe = 1; tick();
        b_pdone = 1; tick();
        b_pdone = 0;
        chk("notx_state", 32'(b_state), 5);
        chk("notx_disc", 32'(b_disc), 1);
        chk("notx_tstart", 32'(b_ts), 0);
        chk("notx_proc", b_proc, 1);
        tick();
        chk("notx_tstart2", 32'(b_ts), 0);

        // 7: 2-bit dropped counter saturates
        for (int n = 0; n < 5; n++) begin
            c_avail = 1; c_fe = 0; tick();
            c_avail = 0; c_fe = 1; tick();
            c_perr = 1; tick();
            c_perr = 0;
            chk($sformatf("sat_drop%0d", n), 32'(c_drop), (n < 3) ? n + 1 : 3);
            tick(); tick();
        end

        // 8: async reset mid-PARSE
        a_to_parse();
        tick();
        chk("ar_pre", 32'(a_state), 3);
        #2 i_areset = 1;
        #1;
        chk("ar_state", 32'(a_state), 0);
        chk("ar_clear", 32'(a_clear), 1);
        chk("ar_busy", 32'(a_busy), 0);
        chk("ar_proc", a_proc, 0);
        chk("ar_drop", a_drop, 0);
        chk("ar_tmo", a_tmo, 0);
        chk("ar_disc", 32'(a_disc), 0);
        tick();
        chk("ar_disc2", 32'(a_disc), 0);
        @(negedge i_clk);
        i_areset = 0;
        tick();
        chk("ar_disc3", 32'(a_disc), 0);
        chk("ar_empty", 32'(a_state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
